// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO behind a CTRL/DATA/STATUS register window.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] BASE_ADDR    = 32'hA000_0000,
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_write_en_i,
  input  logic [XLEN-1:0] mem_write_data_i,
  input  logic            mem_read_en_i,
  output logic [XLEN-1:0] mem_read_data_o,
  output logic            uart_tx_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             tx_en_q;
  logic             overflow_q;

  logic            sel;
  logic [1:0]      reg_off;
  logic            wr_ctrl, wr_data, wr_stat;
  logic            full, empty, push, pop, bit_done;
  logic [XLEN-1:0] status_word;
  logic [XLEN-1:0] rdata_nxt;
  logic            unused_bits;

  assign sel      = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_off  = mem_addr_i[3:2];
  assign wr_ctrl  = mem_write_en_i && sel && (reg_off == 2'd0);
  assign wr_data  = mem_write_en_i && sel && (reg_off == 2'd1);
  assign wr_stat  = mem_write_en_i && sel && (reg_off == 2'd2);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // A full FIFO rejects the store even if the FSM pops in the same cycle.
  assign push     = wr_data && !full;
  assign pop      = (state_q == S_IDLE) && tx_en_q && !empty;
  assign bit_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  assign unused_bits = ^{mem_addr_i[1:0], mem_write_data_i[XLEN-1:8]};

  always_comb begin
    status_word      = '0;
    status_word[0]   = (state_q != S_IDLE);
    status_word[1]   = full;
    status_word[2]   = empty;
    status_word[3]   = overflow_q;
    status_word[8:4] = 5'(count_q);
    rdata_nxt        = '0;
    if (mem_read_en_i && sel) begin
      case (reg_off)
        2'd0:    rdata_nxt[0] = tx_en_q;
        2'd2:    rdata_nxt    = status_word;
        default: rdata_nxt    = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tx_en_q         <= 1'b0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_read_data_o <= '0;
    end else begin
      mem_read_data_o <= rdata_nxt;
      if (wr_ctrl) tx_en_q <= mem_write_data_i[0];
      if (wr_data && full) overflow_q <= 1'b1;
      else if (wr_stat && mem_write_data_i[3]) overflow_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_write_data_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      shift_q  <= fifo_mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_q <= ^fifo_mem[rd_ptr_q];
`endif
    end else if ((state_q == S_DATA) && bit_done && (bit_q != 3'd7)) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Line level is registered alongside each state change, so it tracks state_q exactly.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          uart_tx_o <= 1'b1;
          baud_q    <= '0;
          if (pop) begin
            state_q   <= S_START;
            uart_tx_o <= 1'b0;
          end
        end
        S_START: begin
          if (bit_done) begin
            state_q   <= S_DATA;
            baud_q    <= '0;
            bit_q     <= '0;
            uart_tx_o <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q   <= S_PARITY;
              uart_tx_o <= parity_q;
`else
              state_q   <= S_STOP;
              uart_tx_o <= 1'b1;
`endif
            end else begin
              bit_q     <= bit_q + 3'd1;
              uart_tx_o <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state_q   <= S_STOP;
            baud_q    <= '0;
            uart_tx_o <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            uart_tx_o <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          baud_q    <= '0;
          uart_tx_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: register accesses against a byte-queue model and a
// line monitor that rebuilds each frame from the expected byte.
module tb_uart_tx_ctrl;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PERIOD = NB * C + 1;
  localparam logic [31:0] BASE = 32'hA000_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_DATA = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, tx;

  uart_tx_ctrl #(
    .XLEN(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .resetn_i(resetn), .mem_addr_i(addr), .mem_write_en_i(we),
    .mem_write_data_i(wdata), .mem_read_en_i(re), .mem_read_data_o(rdata), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_started = 0;
  int         frames_done = 0;
  bit         mon_en = 1'b0;

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [31:0] st(input int busy, input int cnt, input int ovf);
    logic [31:0] v;
    v      = '0;
    v[0]   = busy[0];
    v[1]   = (cnt == DEPTH);
    v[2]   = (cnt == 0);
    v[3]   = ovf[0];
    v[8:4] = cnt[4:0];
    return v;
  endfunction

  logic [7:0] mon_b;
  int         mon_ones;
  logic       mon_obs;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        chk("frame_queued", 32'(exp_q.size() > 0), 32'd1);
        mon_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        starts.push_back(cyc);
        frames_started++;
        for (int bi = 0; bi < NB && mon_en; bi++) begin
          mon_ones = 0;
          for (int k = 0; k < C; k++) begin
            if (!(bi == 0 && k == 0)) @(negedge clk);
            if (!mon_en) break;
            if (tx === 1'b1) mon_ones++;
          end
          if (!mon_en) break;
          mon_obs = (mon_ones == C) ? 1'b1 : ((mon_ones == 0) ? 1'b0 : 1'bx);
          chk($sformatf("frame_bit%0d_byte%02h", bi, mon_b), 32'(mon_obs), 32'(exp_bit(mon_b, bi)));
        end
        if (mon_en) frames_done++;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0; addr = '0;
    d = rdata;
  endtask

  task automatic wait_started(input int target, input int budget);
    int n;
    n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_started", frames_started, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_done", frames_done, target);
  endtask

  logic [7:0]  bq[6];
  logic [31:0] d;

  task automatic burst(input int n);
    int cnt, ovf, base, cw;
    cnt = 0; ovf = 0;
    base = frames_started;
    for (int i = 0; i < n; i++) begin
      wr(A_DATA, {24'h0, bq[i]});
      if (cnt < DEPTH) begin
        exp_q.push_back(bq[i]);
        cnt++;
      end else begin
        ovf = 1;
      end
      if (i == DEPTH - 1) begin
        rd_reg(A_STAT, d);
        chk("full_status", d, st(0, cnt, ovf));
      end
    end
    rd_reg(A_STAT, d);
    chk("burst_status", d, st(0, cnt, ovf));
    wr(A_CTRL, 32'h1);
    cw = cyc;
    wait_done(base + cnt, cnt * PERIOD + 50);
    if (starts.size() >= base + cnt) begin
      chk("burst_first_lat", starts[base] - cw, 1);
      for (int j = 1; j < cnt; j++)
        chk("frame_period", starts[base+j] - starts[base+j-1], PERIOD);
    end
    repeat (2) @(negedge clk);
    rd_reg(A_STAT, d);
    chk("burst_drained", d, st(0, 0, ovf));
    wr(A_STAT, 32'h8);
    rd_reg(A_STAT, d);
    chk("ovf_cleared", d, st(0, 0, 0));
    wr(A_CTRL, 32'h0);
    rd_reg(A_CTRL, d);
    chk("ctrl_off", d, 32'h0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base, cw, s, n, nb;
    resetn = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_rdata", rdata, 32'h0);
    resetn = 1'b1;
    mon_en = 1'b1;
    rd_reg(A_STAT, d);
    chk("reset_status", d, 32'h004);
    @(negedge clk);
    chk("rdata_idle", rdata, 32'h0);

    // single frame with busy readback
    wr(A_DATA, 32'h48);
    exp_q.push_back(8'h48);
    wr(A_CTRL, 32'h1);
    cw = cyc;
    wait_started(1, 20);
    if (starts.size() > 0) chk("first_start_lat", starts[0] - cw, 1);
    rd_reg(A_STAT, d);
    chk("busy_mid", d, st(1, 0, 0));
    wait_done(1, PERIOD + 20);
    repeat (2) @(negedge clk);
    rd_reg(A_STAT, d);
    chk("idle_after", d, 32'h004);
    wr(A_CTRL, 32'h0);

    // bursts: fixed "Hello" overflow case, then random lengths/bytes
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        bq[0] = 8'h48; bq[1] = 8'h65; bq[2] = 8'h6C; bq[3] = 8'h6C; bq[4] = 8'h6F;
        nb = 5;
      end else begin
        nb = int'($urandom_range(6, 1));
        for (int i = 0; i < 6; i++) bq[i] = 8'($urandom);
      end
      burst(nb);
    end

    // address window and reserved offsets
    wr(32'hB000_0004, 32'h55);
    wr(BASE + 32'h14, 32'h55);
    wr(BASE + 32'hC, 32'h1);
    rd_reg(A_STAT, d);
    chk("outside_store", d, 32'h004);
    rd_reg(32'hB000_0008, d);
    chk("outside_load", d, 32'h0);
    rd_reg(BASE + 32'hC, d);
    chk("reserved_read", d, 32'h0);
    rd_reg(A_DATA, d);
    chk("data_read", d, 32'h0);

    // clearing tx_en mid-frame
    base = frames_started;
    wr(A_DATA, 32'hA5);
    wr(A_DATA, 32'h3C);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wr(A_CTRL, 32'h1);
    rd_reg(A_CTRL, d);
    chk("ctrl_on", d, 32'h1);
    wait_started(base + 1, 30);
    wr(A_CTRL, 32'h0);
    wait_done(base + 1, PERIOD + 20);
    repeat (60) @(negedge clk);
    chk("no_more_frames", frames_started, base + 1);
    chk("line_idle", 32'(tx), 32'd1);
    rd_reg(A_STAT, d);
    chk("count_one", d, st(0, 1, 0));

    // reset during the first data bit of 0x3C (a low bit)
    base = frames_started;
    wr(A_CTRL, 32'h1);
    wait_started(base + 1, 30);
    s = (starts.size() > base) ? starts[base] : cyc;
    n = 0;
    while (cyc < s + C + 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_low", 32'(tx), 32'd0);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("reset_tx_async", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    rd_reg(A_STAT, d);
    chk("status_after_reset", d, 32'h004);
    rd_reg(A_CTRL, d);
    chk("ctrl_after_reset", d, 32'h0);
    repeat (60) @(negedge clk);
    chk("no_frame_after_reset", frames_started, base + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
